// File: rtl/scale_pkg.sv
// Shared types and constants for the round-robin constant-scaling scheduler.
// Imported by the scheduler top level.
package scale_pkg;

    // Result width growth needed to hold op*8 without truncation.
    localparam int SCALE_OW_EXTRA = 3;

    typedef enum logic [1:0] {
        PH_X1 = 2'd0,
        PH_X3 = 2'd1,
        PH_X7 = 2'd2,
        PH_X8 = 2'd3
    } phase_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after ptr_i,
// wrapping circularly, and returns it both one-hot and encoded.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_oh_o,
    output logic [IW-1:0] grant_idx_o
);

    function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // rot_idx[k] is the requester examined k-th in the circular search.
    logic [IW-1:0] rot_idx [N];
    logic          found;

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot_idx[gi] = rot(ptr_i, gi);
    end

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[rot_idx[k]]) begin
                grant_oh_o[rot_idx[k]] = 1'b1;
                grant_idx_o            = rot_idx[k];
                found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scale_rr_sched.sv
// Round-robin scheduler sharing one 4-phase x1/x3/x7/x8 scaling datapath among
// N_REQ requesters; results stream out tagged with requester ID and phase.
module scale_rr_sched
    import scale_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int DW    = 8,
    localparam int IDW   = $clog2(N_REQ),
    localparam int OW    = DW + SCALE_OW_EXTRA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [OW-1:0]       res_data,
    output logic [IDW-1:0]      res_id,
    output logic [1:0]          res_phase,
    output logic                busy
);

    state_e         state_q;
    phase_e         res_phase_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic [DW-1:0]  op_q;
    logic           res_valid_q;
    logic [OW-1:0]  res_data_q;
    logic [IDW-1:0] res_id_q;
    logic           busy_q;

    logic [N_REQ-1:0] grant_oh;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic [DW-1:0]    sel_data;
    logic [OW-1:0]    op_ext;
    logic [OW-1:0]    op_x3;
    logic [OW-1:0]    op_x7;
    logic [OW-1:0]    op_x8;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx)
    );

    assign req_ready = (state_q == ST_IDLE) ? grant_oh : '0;
    assign accept    = (state_q == ST_IDLE) && (|grant_oh);
    // Only the granted lane is selected, so garbage on other lanes never reaches op_q.
    assign sel_data  = req_data[int'(grant_idx) * DW +: DW];
    assign rr_ptr_d  = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);

    // Shift-add scaling of the latched operand at full result width.
    assign op_ext = OW'(op_q);
    assign op_x8  = op_ext << 3;
    assign op_x3  = op_ext + (op_ext << 1);
    assign op_x7  = op_x8 - op_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_phase_q <= PH_X1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q        <= sel_data;
                        res_id_q    <= grant_idx;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        res_valid_q <= 1'b1;
                        res_phase_q <= PH_X1;
                        res_data_q  <= OW'(sel_data);
                    end
                end
                ST_RUN: begin
                    if (res_ready) begin
                        case (res_phase_q)
                            PH_X1: begin
                                res_phase_q <= PH_X3;
                                res_data_q  <= op_x3;
                            end
                            PH_X3: begin
                                res_phase_q <= PH_X7;
                                res_data_q  <= op_x7;
                            end
                            PH_X7: begin
                                res_phase_q <= PH_X8;
                                res_data_q  <= op_x8;
                            end
                            PH_X8: begin
                                res_valid_q <= 1'b0;
                                state_q     <= ST_IDLE;
                                busy_q      <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_phase = res_phase_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_scale_rr_sched.sv
// Self-checking bench for scale_rr_sched: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_scale_rr_sched;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 11;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [OW-1:0]   res_data;
    logic [1:0]      res_id;
    logic [1:0]      res_phase;
    logic            busy;

    scale_rr_sched #(.N_REQ(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_phase (res_phase),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_grant = 0;
    int mult [4] = '{1, 3, 7, 8};

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Waits (bounded) for a grant and checks which requester got it; leaves us at
    // the negedge of the grant cycle.
    task automatic wait_grant(input int id, input bit spacing, input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            chk({name, "_timeout"}, 0, 1);
            return;
        end
        chk({name, "_grant"}, int'(req_ready), 1 << id);
        if (spacing) chk({name, "_spacing"}, cyc - last_grant, 5);
        last_grant = cyc;
    endtask

    // Checks the four phases of a burst with res_ready held high; rv_after is
    // applied just after the grant edge.
    task automatic expect_burst(input int id, input int op, input logic [N-1:0] rv_after,
                                input string name);
        for (int p = 0; p < 4; p++) begin
            @(posedge clk);
            #1;
            if (p == 0) req_valid = rv_after;
            @(negedge clk);
            chk({name, "_valid"}, int'(res_valid), 1);
            chk({name, "_data"}, int'(res_data), op * mult[p]);
            chk({name, "_phase"}, int'(res_phase), p);
            chk({name, "_id"}, int'(res_id), id);
            chk({name, "_busy"}, int'(busy), 1);
            chk({name, "_noready"}, int'(req_ready), 0);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] rv;
        logic [7:0]   d0;
        logic [N-1:0] rdy;
        logic         v;
        int           data;
        int           ph;
        int           id;
        logic         bsy;
    } vec_t;

    vec_t vecs [11];

    // Behavioural model state
    bit m_busy;
    int m_id, m_op, m_ph, m_ptr, m_grants;

    initial begin
        vecs[0]  = '{4'b0001, 8'd5,   4'b0001, 1'b0, 0,    0, 0, 1'b0};
        vecs[1]  = '{4'b0000, 8'd0,   4'b0000, 1'b1, 5,    0, 0, 1'b1};
        vecs[2]  = '{4'b0000, 8'd0,   4'b0000, 1'b1, 15,   1, 0, 1'b1};
        vecs[3]  = '{4'b0000, 8'd0,   4'b0000, 1'b1, 35,   2, 0, 1'b1};
        vecs[4]  = '{4'b0000, 8'd0,   4'b0000, 1'b1, 40,   3, 0, 1'b1};
        vecs[5]  = '{4'b0001, 8'd255, 4'b0001, 1'b0, 0,    0, 0, 1'b0};
        vecs[6]  = '{4'b0000, 8'd0,   4'b0000, 1'b1, 255,  0, 0, 1'b1};
        vecs[7]  = '{4'b0000, 8'd0,   4'b0000, 1'b1, 765,  1, 0, 1'b1};
        vecs[8]  = '{4'b0000, 8'd0,   4'b0000, 1'b1, 1785, 2, 0, 1'b1};
        vecs[9]  = '{4'b0000, 8'd0,   4'b0000, 1'b1, 2040, 3, 0, 1'b1};
        vecs[10] = '{4'b0000, 8'd0,   4'b0000, 1'b0, 0,    0, 0, 1'b0};

        // Directed vector table; non-granted lanes carry random garbage.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            req_valid = vecs[i].rv;
            req_data  = {$urandom(), $urandom()};
            req_data[7:0] = vecs[i].d0;
            res_ready = 1'b1;
            @(negedge clk);
            $display("[TB] vec %0d: rdy=%b v=%0d data=%0d ph=%0d id=%0d busy=%0d",
                     i, req_ready, res_valid, res_data, res_phase, res_id, busy);
            chk($sformatf("vec%0d_ready", i), int'(req_ready), int'(vecs[i].rdy));
            chk($sformatf("vec%0d_valid", i), int'(res_valid), int'(vecs[i].v));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].bsy));
            if (vecs[i].v || i == 0) begin
                chk($sformatf("vec%0d_data", i), int'(res_data), vecs[i].data);
                chk($sformatf("vec%0d_phase", i), int'(res_phase), vecs[i].ph);
                chk($sformatf("vec%0d_id", i), int'(res_id), vecs[i].id);
            end
            @(posedge clk);
            #1;
        end

        // All four requesting continuously: order 0,1,2,3,0, five cycles apart.
        do_reset();
        req_valid = 4'b1111;
        req_data  = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int k = 0; k < 5; k++) begin
            wait_grant(k % 4, k > 0, $sformatf("rr%0d", k));
            $display("[TB] all-request grant %0d -> requester %0d at cycle %0d", k, k % 4, cyc);
            expect_burst(k % 4, (k % 4) + 1, 4'b1111, $sformatf("rr%0d", k));
        end
        req_valid = '0;

        // Backpressure during phase 1 of operand 10 (requester 1, rr_ptr=1 now).
        req_valid = 4'b0010;
        req_data  = {8'd0, 8'd0, 8'd10, 8'd0};
        wait_grant(1, 1'b0, "bp");
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_ph0_data", int'(res_data), 10);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("bp_hold_data", int'(res_data), 30);
            chk("bp_hold_phase", int'(res_phase), 1);
            chk("bp_hold_valid", int'(res_valid), 1);
            chk("bp_hold_noready", int'(req_ready), 0);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_data", int'(res_data), 30);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_x7_data", int'(res_data), 70);
        chk("bp_x7_phase", int'(res_phase), 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_x8_data", int'(res_data), 80);
        chk("bp_x8_phase", int'(res_phase), 3);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("bp_done_busy", int'(busy), 0);
        $display("[TB] backpressure burst done at cycle %0d", cyc);
        @(posedge clk);
        #1;

        // Fairness and wrap: 3 first, then 0 and 3 both request -> 0 then 3.
        do_reset();
        req_valid = 4'b1000;
        req_data  = {8'd7, 8'd0, 8'd0, 8'd9};
        wait_grant(3, 1'b0, "fw_a");
        expect_burst(3, 7, 4'b1001, "fw_a");
        wait_grant(0, 1'b0, "fw_b");
        expect_burst(0, 9, 4'b1001, "fw_b");
        wait_grant(3, 1'b0, "fw_c");
        expect_burst(3, 7, 4'b0000, "fw_c");
        $display("[TB] fairness/wrap sequence done at cycle %0d", cyc);

        // Asynchronous reset in the middle of phase 2.
        req_valid = 4'b0010;
        req_data  = {8'd0, 8'd0, 8'd20, 8'd0};
        wait_grant(1, 1'b0, "ar");
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", int'(res_valid), 0);
        chk("ar_data", int'(res_data), 0);
        chk("ar_id", int'(res_id), 0);
        chk("ar_phase", int'(res_phase), 0);
        chk("ar_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 4'b0100;
        req_data  = {8'd0, 8'd6, 8'd0, 8'd0};
        wait_grant(2, 1'b0, "ar_post");
        expect_burst(2, 6, 4'b0000, "ar_post");
        @(negedge clk);
        chk("ar_post_idle", int'(busy), 0);
        $display("[TB] async reset sequence done at cycle %0d", cyc);
        @(posedge clk);
        #1;

        // Random traffic against the behavioural model.
        do_reset();
        m_busy = 1'b0; m_id = 0; m_op = 0; m_ph = 0; m_ptr = 0; m_grants = 0;
        for (int c = 0; c < 800; c++) begin
            int g;
            int exp_rdy;
            req_valid = N'($urandom_range(0, 15));
            req_data  = {$urandom(), $urandom()};
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (req_valid[j]) begin
                    g = j;
                    break;
                end
            end
            exp_rdy = (!m_busy && g >= 0) ? (1 << g) : 0;
            chk("rnd_ready", int'(req_ready), exp_rdy);
            chk("rnd_valid", int'(res_valid), int'(m_busy));
            chk("rnd_busy", int'(busy), int'(m_busy));
            if (m_busy) begin
                chk("rnd_data", int'(res_data), m_op * mult[m_ph]);
                chk("rnd_phase", int'(res_phase), m_ph);
                chk("rnd_id", int'(res_id), m_id);
            end
            if (m_busy) begin
                if (res_ready) begin
                    if (m_ph == 3) m_busy = 1'b0;
                    else m_ph = m_ph + 1;
                end
            end else if (g >= 0) begin
                m_busy = 1'b1;
                m_id   = g;
                m_op   = int'(req_data[g*DW +: DW]);
                m_ph   = 0;
                m_ptr  = (g + 1) % N;
                m_grants++;
                $display("[TB] rnd cycle %0d: grant requester %0d operand %0d", c, g, m_op);
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_some_grants", int'(m_grants > 20), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
